// File: rtl/fetch_unit.sv
// Instruction-fetch controller: reads the PC, holds a req/ack read to memory and
// presents the fetched word to IF/ID, driving the PC write enable on consume or redirect.
module fetch_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] pc_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_data_i,
   output logic        pc_write_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   output logic        inst_valid_o,
   output logic [31:0] fetch_cnt_o
);

   typedef enum logic [1:0] {StIdle, StFetch, StDrop, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        valid_q, valid_d;
   logic [31:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         inst_q    <= '0;
         inst_pc_q <= '0;
         valid_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         valid_q   <= valid_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      valid_d   = valid_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         StIdle: begin
            // pc_i is stale during a flush; wait for the redirected PC.
            if (!flush_i && start_i) begin
               addr_d  = pc_i;
               state_d = StFetch;
            end
         end
         StFetch: begin
            if (flush_i && mem_ack_i) begin
               state_d = StIdle;
            end else if (flush_i) begin
               state_d = StDrop;
            end else if (mem_ack_i) begin
               inst_d    = mem_data_i;
               inst_pc_d = addr_q;
               valid_d   = 1'b1;
               state_d   = StHold;
            end
         end
         StDrop: begin
            // Outstanding request completes at the old address; data is discarded.
            if (mem_ack_i) begin
               state_d = StIdle;
            end
         end
         StHold: begin
            if (flush_i) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end else if (!stall_i) begin
               valid_d = 1'b0;
               cnt_d   = cnt_q + 32'd1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign mem_req_o    = (state_q == StFetch) || (state_q == StDrop);
   assign mem_addr_o   = addr_q;
   assign pc_write_o   = flush_i || ((state_q == StHold) && !stall_i);
   assign inst_o       = inst_q;
   assign inst_pc_o    = inst_pc_q;
   assign inst_valid_o = valid_q;
   assign fetch_cnt_o  = cnt_q;

endmodule
